// File: rtl/bus_pkg.sv
// Shared definitions for the begin/end-transaction bus initiator: widths,
// bus-idle values and the initiator state encoding.
package bus_pkg;

  localparam int DATA_W  = 32;
  localparam int BURST_W = 8;
  localparam int BE_W    = 4;

  // Bus is wired-OR, so a non-owning initiator must drive all zeros.
  localparam logic [DATA_W-1:0]  BUS_IDLE_DATA  = '0;
  localparam logic [BE_W-1:0]    BUS_IDLE_BE    = '0;
  localparam logic [BURST_W-1:0] BUS_IDLE_BURST = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEGIN,
    S_RDATA,
    S_WDATA,
    S_WEND,
    S_DONE,
    S_ERR
  } busState_t;

  // States in which the initiator keeps its arbiter request asserted.
  function automatic logic busHeld(input busState_t s);
    return (s inside {S_REQ, S_BEGIN, S_RDATA, S_WDATA, S_WEND});
  endfunction

endpackage

// File: rtl/bus_beat_counter.sv
// Loadable down-counter with zero/last flags; used for beat counting and,
// when enabled, for the idle-bus watchdog.
module bus_beat_counter #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] loadValue_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (load_i) begin
      count <= loadValue_i;
    end else if (dec_i && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_o = (count == '0);
  assign last_o = (count == W'(1));

endmodule

// File: rtl/bus_burst_initiator.sv
// Burst initiator for the shared begin/end-transaction bus.
// Optional idle-bus watchdog is compiled in with `define BUS_TIMEOUT_EN.
module bus_burst_initiator
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // Handshakes: a command transfers on cycles with cmd_valid_i & cmd_ready_o;
  // a write word transfers on cycles with wdata_valid_i & wdata_ready_o.
  // Read data is a strobe (rdata_valid_o) with no backpressure.
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [DATA_W-1:0]   cmd_addr_i,
  input  logic                cmd_read_i,
  input  logic [BURST_W-1:0]  cmd_burst_i,
  input  logic [BE_W-1:0]     cmd_be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rdata_valid_o,
  output logic                done_o,
  output logic                error_o,
  output logic                bus_request_o,
  input  logic                bus_grant_i,
  output logic                bus_beginTransaction_o,
  output logic                bus_endTransaction_o,
  output logic [DATA_W-1:0]   bus_addrData_o,
  output logic [BE_W-1:0]     bus_byteEnables_o,
  output logic [BURST_W-1:0]  bus_burstSize_o,
  output logic                bus_readNWrite_o,
  output logic                bus_dataValid_o,
  input  logic [DATA_W-1:0]   bus_addrData_i,
  input  logic                bus_dataValid_i,
  input  logic                bus_endTransaction_i,
  input  logic                bus_busy_i,
  input  logic                bus_error_i,
  output busState_t           state_o
);

  busState_t state, stateNext;

  logic [DATA_W-1:0]  addrQ;
  logic               readQ;
  logic [BURST_W-1:0] burstQ;
  logic [BE_W-1:0]    beQ;
  logic               errQ;

  logic cmdAccept, rdBeat, wrBeat, cntZero, cntLast, timeout;

  assign cmdAccept = cmd_valid_i & (state == S_IDLE);
  // Beats beyond the programmed burst length are dropped; a bus error masks the beat.
  assign rdBeat    = (state == S_RDATA) & bus_dataValid_i & ~bus_error_i & ~cntZero;
  assign wrBeat    = (state == S_WDATA) & wdata_valid_i & ~bus_busy_i & ~bus_error_i;

  bus_beat_counter #(.W(CNT_W)) uBeatCnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (cmdAccept),
    .loadValue_i (CNT_W'(cmd_burst_i) + CNT_W'(1)),
    .dec_i       (rdBeat | wrBeat),
    .zero_o      (cntZero),
    .last_o      (cntLast)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic inData, toZero, toLast;

  assign inData = (state == S_RDATA) | (state == S_WDATA);

  // Reloaded on entry to the data phase and on each beat; fires on the
  // TIMEOUT_CYCLES-th consecutive beat-less cycle (zero covers a zero limit).
  bus_beat_counter #(.W(TO_W)) uTimeout (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      ((state == S_BEGIN) | rdBeat | wrBeat),
    .loadValue_i (TO_W'(TIMEOUT_CYCLES)),
    .dec_i       (inData),
    .zero_o      (toZero),
    .last_o      (toLast)
  );

  assign timeout = inData & ~(rdBeat | wrBeat) & (toLast | toZero);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addrQ  <= '0;
      readQ  <= 1'b0;
      burstQ <= '0;
      beQ    <= '0;
      errQ   <= 1'b0;
    end else if (cmdAccept) begin
      addrQ  <= cmd_addr_i;
      readQ  <= cmd_read_i;
      burstQ <= cmd_burst_i;
      beQ    <= cmd_be_i;
      errQ   <= 1'b0;
    end else if ((state == S_RDATA) && bus_endTransaction_i) begin
      // Short burst: beats still outstanding once this final beat is counted.
      errQ <= rdBeat ? ~cntLast : ~cntZero;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (cmd_valid_i) stateNext = S_REQ;
      S_REQ:   if (bus_grant_i) stateNext = S_BEGIN;
      S_BEGIN: stateNext = readQ ? S_RDATA : S_WDATA;
      S_RDATA: if (bus_endTransaction_i) stateNext = S_DONE;
      S_WDATA: if (wrBeat && cntLast) stateNext = S_WEND;
      S_WEND:  stateNext = S_DONE;
      S_DONE:  stateNext = S_IDLE;
      S_ERR:   stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    if (timeout) stateNext = S_ERR;
    if (bus_error_i && (state inside {S_BEGIN, S_RDATA, S_WDATA, S_WEND})) stateNext = S_ERR;
  end

  always_comb begin
    bus_beginTransaction_o = 1'b0;
    bus_endTransaction_o   = 1'b0;
    bus_addrData_o         = BUS_IDLE_DATA;
    bus_byteEnables_o      = BUS_IDLE_BE;
    bus_burstSize_o        = BUS_IDLE_BURST;
    bus_readNWrite_o       = 1'b0;
    bus_dataValid_o        = 1'b0;
    case (state)
      S_BEGIN: begin
        bus_beginTransaction_o = 1'b1;
        bus_addrData_o         = addrQ;
        bus_byteEnables_o      = beQ;
        bus_burstSize_o        = burstQ;
        bus_readNWrite_o       = readQ;
      end
      S_WDATA: begin
        bus_addrData_o    = wdata_i;
        bus_byteEnables_o = beQ;
        bus_dataValid_o   = wdata_valid_i;
      end
      S_WEND: begin
        bus_endTransaction_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_ready_o   = (state == S_IDLE);
  assign bus_request_o = busHeld(state);
  assign wdata_ready_o = wrBeat;
  assign rdata_valid_o = rdBeat;
  assign rdata_o       = rdBeat ? bus_addrData_i : '0;
  assign done_o        = (state == S_DONE) | (state == S_ERR);
  assign error_o       = (state == S_ERR) | ((state == S_DONE) & errQ);
  assign state_o       = state;

endmodule

// File: tb/tb_bus_burst_initiator.sv
// Directed bench for bus_burst_initiator: table-driven transactions plus
// hand-written error, reset and silent-slave sequences.
module tb_bus_burst_initiator;
  import bus_pkg::*;

  localparam int TO_CYC = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic        cmd_read_i = 1'b0;
  logic [7:0]  cmd_burst_i = '0;
  logic [3:0]  cmd_be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        wdata_valid_i = 1'b0;
  logic        wdata_ready_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        done_o;
  logic        error_o;
  logic        bus_request_o;
  logic        bus_grant_i = 1'b0;
  logic        bus_beginTransaction_o;
  logic        bus_endTransaction_o;
  logic [31:0] bus_addrData_o;
  logic [3:0]  bus_byteEnables_o;
  logic [7:0]  bus_burstSize_o;
  logic        bus_readNWrite_o;
  logic        bus_dataValid_o;
  logic [31:0] bus_addrData_i = '0;
  logic        bus_dataValid_i = 1'b0;
  logic        bus_endTransaction_i = 1'b0;
  logic        bus_busy_i = 1'b0;
  logic        bus_error_i = 1'b0;
  busState_t   state_o;

  bus_burst_initiator #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(9)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_read_i(cmd_read_i), .cmd_burst_i(cmd_burst_i), .cmd_be_i(cmd_be_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .error_o(error_o),
    .bus_request_o(bus_request_o), .bus_grant_i(bus_grant_i),
    .bus_beginTransaction_o(bus_beginTransaction_o), .bus_endTransaction_o(bus_endTransaction_o),
    .bus_addrData_o(bus_addrData_o), .bus_byteEnables_o(bus_byteEnables_o),
    .bus_burstSize_o(bus_burstSize_o), .bus_readNWrite_o(bus_readNWrite_o),
    .bus_dataValid_o(bus_dataValid_o), .bus_addrData_i(bus_addrData_i),
    .bus_dataValid_i(bus_dataValid_i), .bus_endTransaction_i(bus_endTransaction_i),
    .bus_busy_i(bus_busy_i), .bus_error_i(bus_error_i), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Scoreboard
  int nTests = 0;
  int nFail  = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkBusIdle(input string name);
    check1({name, "_ctl"}, |{bus_beginTransaction_o, bus_endTransaction_o, bus_readNWrite_o,
                             bus_dataValid_o, bus_byteEnables_o, bus_burstSize_o}, 1'b0);
    check32({name, "_ad"}, bus_addrData_o, 32'h0);
  endtask

  // Drivers
  task automatic issueCmd(input logic rd, input logic [31:0] addr, input logic [7:0] burst,
                          input logic [3:0] be);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_read_i  = rd;
    cmd_addr_i  = addr;
    cmd_burst_i = burst;
    cmd_be_i    = be;
    #1;
    check1("cmd_ready", cmd_ready_o, 1'b1);
  endtask

  task automatic grantPhase(input int delay, input logic rd, input logic [31:0] addr,
                            input logic [7:0] burst, input logic [3:0] be);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      bus_grant_i = 1'b0;
      #1;
      check1("req_wait", bus_request_o, 1'b1);
      checkBusIdle("pre_grant");
    end
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    bus_grant_i = 1'b1;
    #1;
    check1("req_grant", bus_request_o, 1'b1);
    checkBusIdle("grant_cycle");
    @(negedge clk_i);
    bus_grant_i = 1'b0;
    #1;
    check1("begin", bus_beginTransaction_o, 1'b1);
    check32("begin_addr", bus_addrData_o, addr);
    check32("begin_ctl", {19'h0, bus_burstSize_o, bus_byteEnables_o, bus_readNWrite_o},
            {19'h0, burst, be, rd});
  endtask

  task automatic readPhase(input int nBeats, input logic [7:0] burst, input logic [31:0] base,
                           input logic [31:0] step, input logic expErr);
    int strobes;
    int expStrobes;
    strobes = 0;
    exp_q.delete();
    expStrobes = (nBeats < int'(burst) + 1) ? nBeats : int'(burst) + 1;
    for (int i = 0; i < expStrobes; i++) exp_q.push_back(base + step * i);
    for (int i = 0; i < nBeats; i++) begin
      @(negedge clk_i);
      bus_dataValid_i      = 1'b1;
      bus_addrData_i       = base + step * i;
      bus_endTransaction_i = (i == nBeats - 1);
      #1;
      if (rdata_valid_o) begin
        strobes++;
        if (exp_q.size() > 0) check32("rdata", rdata_o, exp_q.pop_front());
      end
    end
    @(negedge clk_i);
    bus_dataValid_i      = 1'b0;
    bus_addrData_i       = '0;
    bus_endTransaction_i = 1'b0;
    #1;
    check32("rd_strobes", strobes, expStrobes);
    check1("rd_done", done_o, 1'b1);
    check1("rd_error", error_o, expErr);
    check1("rd_req_released", bus_request_o, 1'b0);
    @(negedge clk_i);
    #1;
    check1("rd_idle_ready", cmd_ready_o, 1'b1);
    check1("rd_done_clear", done_o, 1'b0);
  endtask

  task automatic writePhase(input int nBeats, input logic [31:0] base, input logic [31:0] step,
                            input int busyBeat, input int busyCycles);
    int accepted;
    logic [31:0] d;
    accepted = 0;
    exp_q.delete();
    for (int i = 0; i < nBeats; i++) exp_q.push_back(base + step * i);
    for (int i = 0; i < nBeats; i++) begin
      d = base + step * i;
      for (int b = 0; b < ((i == busyBeat) ? busyCycles : 0); b++) begin
        @(negedge clk_i);
        wdata_valid_i = 1'b1;
        wdata_i       = d;
        bus_busy_i    = 1'b1;
        #1;
        check1("wr_hold_dv", bus_dataValid_o, 1'b1);
        check32("wr_hold_data", bus_addrData_o, d);
        check1("wr_hold_ready", wdata_ready_o, 1'b0);
      end
      @(negedge clk_i);
      wdata_valid_i = 1'b1;
      wdata_i       = d;
      bus_busy_i    = 1'b0;
      #1;
      check1("wr_dv", bus_dataValid_o, 1'b1);
      if (wdata_ready_o) begin
        accepted++;
        if (exp_q.size() > 0) check32("wr_data", bus_addrData_o, exp_q.pop_front());
      end
    end
    @(negedge clk_i);
    wdata_valid_i = 1'b0;
    wdata_i       = '0;
    #1;
    check32("wr_accepted", accepted, nBeats);
    check1("wr_end", bus_endTransaction_o, 1'b1);
    check1("wr_end_dv", bus_dataValid_o, 1'b0);
    @(negedge clk_i);
    #1;
    check1("wr_done", done_o, 1'b1);
    check1("wr_error", error_o, 1'b0);
    checkBusIdle("wr_done_bus");
    @(negedge clk_i);
    #1;
    check1("wr_idle_ready", cmd_ready_o, 1'b1);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [7:0]  burst;
    logic [3:0]  be;
    int          grantDelay;
    int          slaveBeats;
    logic [31:0] base;
    logic [31:0] step;
    int          busyBeat;
    int          busyCycles;
    logic        expErr;
  } vec_t;

  vec_t vecs[6];
  logic doneSeen;
  int   waited;

  initial begin
    vecs[0] = '{1'b1, 32'h100, 8'd0, 4'hF, 0,  1, 32'hDEADBEEF, 32'h0,  -1, 0, 1'b0};
    vecs[1] = '{1'b0, 32'h200, 8'd3, 4'hF, 1,  4, 32'h11,       32'h11,  1, 2, 1'b0};
    vecs[2] = '{1'b1, 32'h300, 8'd7, 4'hF, 0,  5, 32'hA0,       32'h1,  -1, 0, 1'b1};
    vecs[3] = '{1'b1, 32'h400, 8'd1, 4'h3, 2,  4, 32'h5000,     32'h10, -1, 0, 1'b0};
    vecs[4] = '{1'b0, 32'h500, 8'd0, 4'h8, 0,  1, 32'hCAFE0000, 32'h0,  -1, 0, 1'b0};
    vecs[5] = '{1'b1, 32'h600, 8'd2, 4'hC, 10, 3, 32'h1234,     32'h101, -1, 0, 1'b0};

    // Reset state
    #3;
    check1("rst_cmd_ready", cmd_ready_o, 1'b1);
    checkBusIdle("rst_bus");
    check1("rst_outs", |{bus_request_o, done_o, error_o, rdata_valid_o, wdata_ready_o}, 1'b0);
    check32("rst_rdata", rdata_o, 32'h0);
    check32("rst_state", 32'(state_o), 32'(S_IDLE));
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int v = 0; v < 6; v++) begin
      issueCmd(vecs[v].rd, vecs[v].addr, vecs[v].burst, vecs[v].be);
      grantPhase(vecs[v].grantDelay, vecs[v].rd, vecs[v].addr, vecs[v].burst, vecs[v].be);
      if (vecs[v].rd)
        readPhase(vecs[v].slaveBeats, vecs[v].burst, vecs[v].base, vecs[v].step, vecs[v].expErr);
      else
        writePhase(int'(vecs[v].burst) + 1, vecs[v].base, vecs[v].step,
                   vecs[v].busyBeat, vecs[v].busyCycles);
    end

    // Bus error during the first write beat of four
    issueCmd(1'b0, 32'h700, 8'd3, 4'hF);
    grantPhase(0, 1'b0, 32'h700, 8'd3, 4'hF);
    @(negedge clk_i);
    wdata_valid_i = 1'b1;
    wdata_i       = 32'h77;
    bus_error_i   = 1'b1;
    #1;
    check1("werr_ready", wdata_ready_o, 1'b0);
    @(negedge clk_i);
    bus_error_i   = 1'b0;
    wdata_valid_i = 1'b0;
    #1;
    checkBusIdle("werr_bus");
    check1("werr_done", done_o, 1'b1);
    check1("werr_error", error_o, 1'b1);
    check1("werr_req", bus_request_o, 1'b0);
    @(negedge clk_i);
    #1;
    check1("werr_ready_after", cmd_ready_o, 1'b1);
    check1("werr_done_clear", done_o, 1'b0);

    // Error coinciding with the final read beat wins
    issueCmd(1'b1, 32'h800, 8'd0, 4'hF);
    grantPhase(0, 1'b1, 32'h800, 8'd0, 4'hF);
    @(negedge clk_i);
    bus_dataValid_i      = 1'b1;
    bus_addrData_i       = 32'h55AA55AA;
    bus_endTransaction_i = 1'b1;
    bus_error_i          = 1'b1;
    #1;
    @(negedge clk_i);
    bus_dataValid_i      = 1'b0;
    bus_addrData_i       = '0;
    bus_endTransaction_i = 1'b0;
    bus_error_i          = 1'b0;
    #1;
    check1("rlast_err_done", done_o, 1'b1);
    check1("rlast_err_error", error_o, 1'b1);
    check32("rlast_err_state", 32'(state_o), 32'(S_ERR));

    // Asynchronous reset in the middle of a write
    issueCmd(1'b0, 32'h900, 8'd1, 4'hF);
    grantPhase(0, 1'b0, 32'h900, 8'd1, 4'hF);
    @(negedge clk_i);
    wdata_valid_i = 1'b1;
    wdata_i       = 32'h99;
    bus_busy_i    = 1'b1;
    #1;
    check1("mid_dv", bus_dataValid_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkBusIdle("mid_rst_bus");
    check1("mid_rst_outs", |{bus_request_o, done_o, error_o, wdata_ready_o, rdata_valid_o}, 1'b0);
    check1("mid_rst_ready", cmd_ready_o, 1'b1);
    check32("mid_rst_state", 32'(state_o), 32'(S_IDLE));
    @(negedge clk_i);
    wdata_valid_i = 1'b0;
    bus_busy_i    = 1'b0;
    rst_ni        = 1'b1;
    doneSeen      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      if (done_o) doneSeen = 1'b1;
    end
    check1("mid_rst_no_done", doneSeen, 1'b0);

    // Silent slave after a read begin
    issueCmd(1'b1, 32'hA00, 8'd0, 4'hF);
    grantPhase(0, 1'b1, 32'hA00, 8'd0, 4'hF);
`ifdef BUS_TIMEOUT_EN
    doneSeen = 1'b0;
    waited   = 0;
    for (int i = 0; i < 40 && !doneSeen; i++) begin
      @(negedge clk_i);
      #1;
      if (done_o) doneSeen = 1'b1;
      else waited++;
    end
    check1("to_done", doneSeen, 1'b1);
    check1("to_error", error_o, 1'b1);
    check32("to_cycles", waited, TO_CYC);
`else
    doneSeen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      #1;
      if (done_o) doneSeen = 1'b1;
    end
    check1("silent_no_done", doneSeen, 1'b0);
    check1("silent_req", bus_request_o, 1'b1);
    check32("silent_state", 32'(state_o), 32'(S_RDATA));
    @(negedge clk_i);
    bus_error_i = 1'b1;
    #1;
    @(negedge clk_i);
    bus_error_i = 1'b0;
    #1;
    check1("silent_err_done", done_o, 1'b1);
    check1("silent_err_error", error_o, 1'b1);
`endif
    @(negedge clk_i);
    #1;
    check1("final_ready", cmd_ready_o, 1'b1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
